// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       irwrite;
   logic       regwrite;
   logic       memwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       illegal;

   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol, state, illegal
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, alucontrol, state, illegal
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with registered controls plus ALU decoder.
// Define MC_BNE_EN to add the bne instruction (state 12).
module mc_controller (
   input  logic            clk,
   input  logic            reset,
   mc_controller_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_BNE     = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       branch_ne;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Moore control word for a state; enables are gated later by mem_ready/zero/reset.
   function automatic ctrl_t decode_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
         S_DECODE:  c.alusrcb = 2'b11;
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
         S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         S_BEQ:     begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
`ifdef MC_BNE_EN
         S_BNE:     begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch_ne = 1'b1; end
`endif
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_ADDIWB:  c.regwrite = 1'b1;
         S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
         default:   ;
      endcase
      return c;
   endfunction

   state_t r_state;
   ctrl_t  r_ctrl;
   state_t w_next;
   state_t w_decode_target;
   logic   w_gate;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_decode_target = S_FETCH;
      case (bus.op)
         OP_LW, OP_SW: w_decode_target = S_MEMADR;
         OP_RTYPE:     w_decode_target = S_RTYPEEX;
         OP_BEQ:       w_decode_target = S_BEQ;
`ifdef MC_BNE_EN
         OP_BNE:       w_decode_target = S_BNE;
`endif
         OP_ADDI:      w_decode_target = S_ADDIEX;
         OP_J:         w_decode_target = S_JUMP;
         default:      w_decode_target = S_FETCH;
      endcase
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:   w_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:  w_next = w_decode_target;
         S_MEMADR:  w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: w_next = S_RTYPEWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         default:   w_next = S_FETCH;
      endcase
   end

   // Controls are registered from the next state so they are glitch-free Moore outputs.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_ctrl  <= decode_ctrl(S_FETCH);
      end else begin
         r_state <= w_next;
         r_ctrl  <= decode_ctrl(w_next);
      end
   end

   // Only FETCH and MEMWR hand their enables to the memory handshake.
   assign w_gate = reset & (((r_state == S_FETCH) || (r_state == S_MEMWR)) ? bus.mem_ready : 1'b1);

   always_comb begin
      bus.alucontrol = 3'b010;
      case (r_ctrl.aluop)
         ALUOP_SUB:   bus.alucontrol = 3'b110;
         ALUOP_FUNCT: begin
            case (bus.funct)
               6'b100010: bus.alucontrol = 3'b110;
               6'b100100: bus.alucontrol = 3'b000;
               6'b100101: bus.alucontrol = 3'b001;
               6'b101010: bus.alucontrol = 3'b111;
               default:   bus.alucontrol = 3'b010;
            endcase
         end
         default:     bus.alucontrol = 3'b010;
      endcase
   end

   assign bus.pcen     = w_gate & (r_ctrl.pcwrite | (r_ctrl.branch & bus.zero)
                                   | (r_ctrl.branch_ne & ~bus.zero));
   assign bus.irwrite  = w_gate & r_ctrl.irwrite;
   assign bus.regwrite = w_gate & r_ctrl.regwrite;
   assign bus.memwrite = w_gate & r_ctrl.memwrite;
   assign bus.iord     = r_ctrl.iord;
   assign bus.memtoreg = r_ctrl.memtoreg;
   assign bus.regdst   = r_ctrl.regdst;
   assign bus.alusrca  = r_ctrl.alusrca;
   assign bus.alusrcb  = r_ctrl.alusrcb;
   assign bus.pcsrc    = r_ctrl.pcsrc;
   assign bus.state    = r_state;
   assign bus.illegal  = reset & (r_state == S_DECODE) & (w_decode_target == S_FETCH);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed table, corner sequences, randomized instruction stream.
module tb_mc_controller;

   typedef struct packed {
      logic       pcen;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
      logic [3:0] state;
      logic       illegal;
   } obs_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      logic       ill;
      bit         chk_alu;
      logic [2:0] alu3;
      logic [3:0] last_state;
      logic       pcen_last;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   obs_t trace[$];
   vec_t vq[$];

   mc_controller_if bus ();

   mc_controller u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.pcen = bus.pcen;         o.irwrite = bus.irwrite;   o.regwrite = bus.regwrite;
      o.memwrite = bus.memwrite; o.iord = bus.iord;         o.memtoreg = bus.memtoreg;
      o.regdst = bus.regdst;     o.alusrca = bus.alusrca;   o.alusrcb = bus.alusrcb;
      o.pcsrc = bus.pcsrc;       o.alucontrol = bus.alucontrol;
      o.state = bus.state;       o.illegal = bus.illegal;
      return o;
   endfunction

   function automatic bit op_legal(logic [5:0] op);
      case (op)
         6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_BNE_EN
         6'b000101: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected outputs for one cycle of an instruction step, straight from the control table.
   function automatic obs_t model(int s, logic [5:0] op, logic [5:0] funct, logic z, logic mr);
      obs_t e;
      e = '0;
      e.state = 4'(s);
      case (s)
         0:  begin e.alusrcb = 2'b01; e.alucontrol = 3'b010; e.irwrite = mr; e.pcen = mr; end
         1:  begin e.alusrcb = 2'b11; e.alucontrol = 3'b010; e.illegal = !op_legal(op); end
         2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
         3:  e.iord = 1'b1;
         4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         5:  begin e.iord = 1'b1; e.memwrite = mr; end
         6:  begin e.alusrca = 1'b1; e.alucontrol = funct_alu(funct); end
         7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
         8:  begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
         9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
         10: e.regwrite = 1'b1;
         11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
         12: begin e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = !z; end
         default: ;
      endcase
      return e;
   endfunction

   // alucontrol is only meaningful in steps that actually use the ALU.
   function automatic obs_t care(int s);
      obs_t c;
      c = '1;
      if (s == 3 || s == 4 || s == 5 || s == 7 || s == 10 || s == 11) c.alucontrol = '0;
      return c;
   endfunction

   // Runs one instruction from FETCH, checking every cycle; per-instruction step list is the model.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                            input logic zfix, input bit rnd, input logic [15:0] mr_pat);
      int   path[$];
      int   idx;
      int   cyc;
      obs_t act, e, m;
      logic z, mr;
      path.push_back(0);
      path.push_back(1);
      case (op)
         6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
         6'b101011: begin path.push_back(2); path.push_back(5); end
         6'b000000: begin path.push_back(6); path.push_back(7); end
         6'b000100: path.push_back(8);
         6'b001000: begin path.push_back(9); path.push_back(10); end
         6'b000010: path.push_back(11);
`ifdef MC_BNE_EN
         6'b000101: path.push_back(12);
`endif
         default: ;
      endcase
      trace.delete();
      bus.op = op;
      bus.funct = funct;
      idx = 0;
      cyc = 0;
      while (idx < path.size() && cyc < 64) begin
         mr = rnd ? logic'($urandom_range(0, 3) != 0) : ((cyc < 16) ? mr_pat[cyc] : 1'b1);
         z  = rnd ? logic'($urandom_range(0, 1)) : zfix;
         bus.mem_ready = mr;
         bus.zero = z;
         #1;
         act = sample();
         e = model(path[idx], op, funct, z, mr);
         m = care(path[idx]);
         check($sformatf("%s cyc%0d", name, cyc), {12'b0, act & m}, {12'b0, e & m});
         trace.push_back(act);
         cyc++;
         if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mr)) idx++;
         @(posedge clk);
         #1;
      end
      if (idx < path.size()) check({name, " timeout"}, 32'(idx), 32'(path.size()));
      check({name, " back_to_fetch"}, {28'b0, bus.state}, 32'd0);
   endtask

   task automatic add_vec(input string n, input logic [5:0] op, input logic [5:0] f, input logic z,
                          input logic ill, input bit ca, input logic [2:0] a3,
                          input logic [3:0] ls, input logic pl);
      vec_t v;
      v.name = n; v.op = op; v.funct = f; v.zero = z; v.ill = ill;
      v.chk_alu = ca; v.alu3 = a3; v.last_state = ls; v.pcen_last = pl;
      vq.push_back(v);
   endtask

   initial begin
      obs_t last;
      int   wr_cnt;
      logic [5:0] pool_op[8];
      logic [5:0] pool_fn[6];

      //        name        op         funct      z     ill   alu  alu3    last   pcen
      add_vec("lw",       6'b100011, 6'b000000, 1'b0, 1'b0, 1, 3'b010, 4'd4,  1'b0);
      add_vec("sw",       6'b101011, 6'b000000, 1'b0, 1'b0, 1, 3'b010, 4'd5,  1'b0);
      add_vec("r_add",    6'b000000, 6'b100000, 1'b0, 1'b0, 1, 3'b010, 4'd7,  1'b0);
      add_vec("r_sub",    6'b000000, 6'b100010, 1'b0, 1'b0, 1, 3'b110, 4'd7,  1'b0);
      add_vec("r_and",    6'b000000, 6'b100100, 1'b0, 1'b0, 1, 3'b000, 4'd7,  1'b0);
      add_vec("r_or",     6'b000000, 6'b100101, 1'b0, 1'b0, 1, 3'b001, 4'd7,  1'b0);
      add_vec("r_slt",    6'b000000, 6'b101010, 1'b0, 1'b0, 1, 3'b111, 4'd7,  1'b0);
      add_vec("r_unk",    6'b000000, 6'b000111, 1'b0, 1'b0, 1, 3'b010, 4'd7,  1'b0);
      add_vec("beq_z1",   6'b000100, 6'b000000, 1'b1, 1'b0, 1, 3'b110, 4'd8,  1'b1);
      add_vec("beq_z0",   6'b000100, 6'b000000, 1'b0, 1'b0, 1, 3'b110, 4'd8,  1'b0);
      add_vec("addi",     6'b001000, 6'b000000, 1'b0, 1'b0, 1, 3'b010, 4'd10, 1'b0);
      add_vec("j",        6'b000010, 6'b000000, 1'b0, 1'b0, 0, 3'b000, 4'd11, 1'b1);
      add_vec("ill_3f",   6'b111111, 6'b000000, 1'b0, 1'b1, 0, 3'b000, 4'd1,  1'b0);
`ifdef MC_BNE_EN
      add_vec("bne_z0",   6'b000101, 6'b000000, 1'b0, 1'b0, 1, 3'b110, 4'd12, 1'b1);
      add_vec("bne_z1",   6'b000101, 6'b000000, 1'b1, 1'b0, 1, 3'b110, 4'd12, 1'b0);
`else
      add_vec("bne_ill",  6'b000101, 6'b000000, 1'b0, 1'b1, 0, 3'b000, 4'd1,  1'b0);
`endif

      bus.op = 6'b000000; bus.funct = 6'b000000; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst state",      {28'b0, bus.state},      32'd0);
      check("rst alusrcb",    {30'b0, bus.alusrcb},    32'd1);
      check("rst pcsrc",      {30'b0, bus.pcsrc},      32'd0);
      check("rst alucontrol", {29'b0, bus.alucontrol}, 32'd2);
      check("rst irwrite",    {31'b0, bus.irwrite},    32'd0);
      check("rst pcen",       {31'b0, bus.pcen},       32'd0);
      check("rst memwrite",   {31'b0, bus.memwrite},   32'd0);
      reset = 1'b1;
      #1;
      check("rel state",   {28'b0, bus.state},   32'd0);
      check("rel irwrite", {31'b0, bus.irwrite}, 32'd1);
      check("rel pcen",    {31'b0, bus.pcen},    32'd1);
      check("rel alusrcb", {30'b0, bus.alusrcb}, 32'd1);

      foreach (vq[i]) begin
         run_instr(vq[i].name, vq[i].op, vq[i].funct, vq[i].zero, 1'b0, 16'hFFFF);
         last = trace[trace.size() - 1];
         check({vq[i].name, " illegal"}, {31'b0, trace[1].illegal}, {31'b0, vq[i].ill});
         if (vq[i].chk_alu)
            check({vq[i].name, " alu3"}, {29'b0, trace[2].alucontrol}, {29'b0, vq[i].alu3});
         check({vq[i].name, " last_state"}, {28'b0, last.state}, {28'b0, vq[i].last_state});
         check({vq[i].name, " last_pcen"}, {31'b0, last.pcen}, {31'b0, vq[i].pcen_last});
      end

      // addi then sw: regwrite in cycle 4, a single memwrite in cycle 8
      run_instr("seq_addi", 6'b001000, 6'b000000, 1'b0, 1'b0, 16'hFFFF);
      check("seq_addi c4 regwrite", {31'b0, trace[3].regwrite}, 32'd1);
      wr_cnt = 0;
      foreach (trace[i]) wr_cnt += int'(trace[i].memwrite);
      run_instr("seq_sw", 6'b101011, 6'b000000, 1'b0, 1'b0, 16'hFFFF);
      foreach (trace[i]) wr_cnt += int'(trace[i].memwrite);
      check("seq_sw c8 memwrite&iord", {31'b0, trace[3].memwrite & trace[3].iord}, 32'd1);
      check("seq memwrite count", 32'(wr_cnt), 32'd1);

      // lw with memory stalled three cycles in MEMRD
      run_instr("lw_stall", 6'b100011, 6'b000000, 1'b0, 1'b0, 16'hFFC7);
      check("lw_stall len", 32'(trace.size()), 32'd8);
      for (int k = 3; k < 7; k++)
         check($sformatf("lw_stall memrd%0d", k), {28'b0, trace[k].state}, 32'd3);
      check("lw_stall wb", {29'b0, trace[7].state[2:0] == 3'd4, trace[7].regwrite, trace[7].memtoreg},
            32'h7);

      // fetch stall and store stall
      run_instr("fetch_stall", 6'b000000, 6'b100000, 1'b0, 1'b0, 16'hFFFC);
      check("fetch_stall irwrite", {31'b0, trace[0].irwrite | trace[1].irwrite}, 32'd0);
      run_instr("sw_stall", 6'b101011, 6'b000000, 1'b0, 1'b0, 16'hFFE7);
      check("sw_stall memwrite", {30'b0, trace[3].memwrite, trace[5].memwrite}, 32'd1);

      // reset in the middle of an R-type abandons it
      bus.op = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1; bus.zero = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("abort pre state", {28'b0, bus.state}, 32'd6);
      reset = 1'b0;
      #1;
      check("abort state", {28'b0, bus.state}, 32'd0);
      check("abort enables", {28'b0, bus.regwrite, bus.irwrite, bus.pcen, bus.memwrite}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // randomized stream
      pool_op = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b0};
      pool_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b0};
      for (int n = 0; n < 150; n++) begin
         logic [5:0] op, fn;
         int pick;
         pick = int'($urandom_range(0, 7));
         op = (pick == 7) ? 6'($urandom_range(0, 63)) : pool_op[pick];
         pick = int'($urandom_range(0, 5));
         fn = (pick == 5) ? 6'($urandom_range(0, 63)) : pool_fn[pick];
         run_instr($sformatf("rnd%0d op%02h", n, op), op, fn, 1'b0, 1'b1, 16'hFFFF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
